// File: rtl/tile_fetch_ctrl.sv
// tile_fetch_ctrl: walks a job of tiles through a BRAM read port and streams
// the returned beats out over a valid/ready interface.
//
// A job is num_tiles tiles (0 means 256) of NUM_FETCHES_PER_TILE beats each.
// Beat addresses are tile_base + beat, with tile_base starting at base_addr
// and advancing by tile_stride per tile (both sums wrap at 2^ADDR_WIDTH).
// Reads are credit-limited so that in-flight reads plus skid FIFO occupancy
// never exceed BRAM_LATENCY+1, which is exactly enough for one beat per cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, abort        job request (IDLE only) / cancel current job
//   base_addr, num_tiles, tile_stride   job descriptor, sampled on start
//   bram_en, bram_addr, bram_dout       BRAM read port
//   out_data, out_valid, out_ready, out_last   output stream
//   tile_done, job_done pulses on the last-beat / final handshake
//   busy                high from accepted start until back in IDLE
//   stall_cycles        only with TILE_FETCH_PERF_CNT_EN: saturating count of
//                       cycles with out_valid=1 and out_ready=0
//
// Optional feature macro: TILE_FETCH_PERF_CNT_EN
module tile_fetch_ctrl #(
    parameter int unsigned ADDR_WIDTH           = 11,
    parameter int unsigned DATA_WIDTH           = 256,
    parameter int unsigned NUM_FETCHES_PER_TILE = 32,
    parameter int unsigned BRAM_LATENCY         = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [7:0]            num_tiles,
    input  logic [ADDR_WIDTH-1:0] tile_stride,
    input  logic                  abort,
    output logic                  bram_en,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    input  logic [DATA_WIDTH-1:0] bram_dout,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  tile_done,
    output logic                  job_done,
    output logic                  busy
`ifdef TILE_FETCH_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);

    localparam int unsigned DEPTH  = BRAM_LATENCY + 1;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned SLOTS  = 1 << PTR_W;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned BEAT_W = (NUM_FETCHES_PER_TILE > 1) ? $clog2(NUM_FETCHES_PER_TILE) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  state_q, state_d;
    logic [BEAT_W-1:0]       beat_q;
    logic [ADDR_WIDTH-1:0]   tile_base_q;
    logic [ADDR_WIDTH-1:0]   stride_q;
    logic [8:0]              tiles_left_q;
    logic [CNT_W-1:0]        pend_q;
    logic [BRAM_LATENCY-1:0] pipe_vld_q, pipe_last_q, pipe_jlast_q;
    logic [DATA_WIDTH-1:0]   fifo_data_q [SLOTS];
    logic [SLOTS-1:0]        fifo_last_q, fifo_jlast_q;
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]        cnt_q;

    logic accept, kill, pop, push, last_beat, last_job;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign accept    = (state_q == IDLE) && start;
    assign kill      = rst || (abort && (state_q != IDLE));
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign push      = pipe_vld_q[BRAM_LATENCY-1];
    assign last_beat = (beat_q == BEAT_W'(NUM_FETCHES_PER_TILE - 1));
    assign last_job  = last_beat && (tiles_left_q == 9'd1);
    assign bram_addr = tile_base_q + ADDR_WIDTH'(beat_q);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign out_last  = out_valid && fifo_last_q[rd_ptr_q];
    assign tile_done = pop && out_last && !kill;
    assign job_done  = tile_done && fifo_jlast_q[rd_ptr_q];

    // Next state and read issue; a pop this cycle frees a credit immediately
    // so a full pipeline keeps issuing one read per cycle.
    always_comb begin
        state_d = state_q;
        bram_en = 1'b0;
        case (state_q)
            IDLE:  if (start) state_d = ISSUE;
            ISSUE: begin
                bram_en = (pend_q < CNT_W'(DEPTH)) || pop;
                if (bram_en && last_job) state_d = DRAIN;
            end
            DRAIN: if ((pend_q == '0) || ((pend_q == CNT_W'(1)) && pop)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) begin
            state_d = IDLE;
            bram_en = 1'b0;
        end
    end

    // Control state, address walk, read tag pipeline and FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            tile_base_q  <= '0;
            stride_q     <= '0;
            tiles_left_q <= '0;
            pend_q       <= '0;
            pipe_vld_q   <= '0;
            pipe_last_q  <= '0;
            pipe_jlast_q <= '0;
            fifo_last_q  <= '0;
            fifo_jlast_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q <= state_d;
            pipe_last_q[0]  <= last_beat;
            pipe_jlast_q[0] <= last_job;
            for (int k = 1; k < int'(BRAM_LATENCY); k++) begin
                pipe_last_q[k]  <= pipe_last_q[k-1];
                pipe_jlast_q[k] <= pipe_jlast_q[k-1];
            end
            if (kill) begin
                // Flush everything; late BRAM returns find no valid tag.
                pend_q     <= '0;
                pipe_vld_q <= '0;
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                cnt_q      <= '0;
            end else begin
                pend_q        <= pend_q + CNT_W'(bram_en) - CNT_W'(pop);
                pipe_vld_q[0] <= bram_en;
                for (int k = 1; k < int'(BRAM_LATENCY); k++) begin
                    pipe_vld_q[k] <= pipe_vld_q[k-1];
                end
                if (push) begin
                    fifo_last_q[wr_ptr_q]  <= pipe_last_q[BRAM_LATENCY-1];
                    fifo_jlast_q[wr_ptr_q] <= pipe_jlast_q[BRAM_LATENCY-1];
                    wr_ptr_q               <= ptr_inc(wr_ptr_q);
                end
                if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
                cnt_q <= cnt_q + CNT_W'(push) - CNT_W'(pop);
            end
            if (accept) begin
                tile_base_q  <= base_addr;
                stride_q     <= tile_stride;
                beat_q       <= '0;
                tiles_left_q <= (num_tiles == 8'd0) ? 9'd256 : {1'b0, num_tiles};
            end else if (bram_en) begin
                if (last_beat) begin
                    beat_q       <= '0;
                    tile_base_q  <= tile_base_q + stride_q;
                    tiles_left_q <= tiles_left_q - 9'd1;
                end else begin
                    beat_q <= beat_q + BEAT_W'(1);
                end
            end
        end
    end

    // Skid FIFO payload storage; occupancy is tracked above.
    always_ff @(posedge clk) begin
        if (push) fifo_data_q[wr_ptr_q] <= bram_dout;
    end

`ifdef TILE_FETCH_PERF_CNT_EN
    // Saturating stall counter, restarted by each accepted job.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (accept) begin
            stall_cycles <= '0;
        end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tile_fetch_ctrl.sv
// Directed bench for tile_fetch_ctrl: dut (BRAM_LATENCY=1) and dut2
// (BRAM_LATENCY=2) share job inputs; each has its own out_ready and BRAM model.
module tb_tile_fetch_ctrl;
    localparam int unsigned AW = 11;
    localparam int unsigned DW = 256;
    localparam int unsigned NF = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, abort, ready, ready2;
    logic [AW-1:0] base, stride;
    logic [7:0]    ntiles;

    logic          bram_en, out_valid, out_last, tile_done, job_done, busy;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_dout, out_data;
    logic          bram_en2, out_valid2, out_last2, tile_done2, job_done2, busy2;
    logic [AW-1:0] bram_addr2;
    logic [DW-1:0] bram_dout2, out_data2, mid2;
`ifdef TILE_FETCH_PERF_CNT_EN
    logic [31:0]   stall_cycles, stall_cycles2;
`endif

    int checks = 0;
    int errors = 0;

    tile_fetch_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base), .num_tiles(ntiles),
        .tile_stride(stride), .abort(abort), .bram_en(bram_en), .bram_addr(bram_addr),
        .bram_dout(bram_dout), .out_data(out_data), .out_valid(out_valid),
        .out_ready(ready), .out_last(out_last), .tile_done(tile_done),
        .job_done(job_done), .busy(busy)
`ifdef TILE_FETCH_PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    tile_fetch_ctrl #(.BRAM_LATENCY(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base), .num_tiles(ntiles),
        .tile_stride(stride), .abort(abort), .bram_en(bram_en2), .bram_addr(bram_addr2),
        .bram_dout(bram_dout2), .out_data(out_data2), .out_valid(out_valid2),
        .out_ready(ready2), .out_last(out_last2), .tile_done(tile_done2),
        .job_done(job_done2), .busy(busy2)
`ifdef TILE_FETCH_PERF_CNT_EN
        , .stall_cycles(stall_cycles2)
`endif
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        pat = {16{5'h15, a}};
    endfunction

    function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] b, input logic [AW-1:0] s, input int idx);
        exp_addr = AW'(b + AW'(idx / NF) * s + AW'(idx % NF));
    endfunction

    // BRAM models: one-cycle and two-cycle read latency.
    always @(posedge clk) if (bram_en) bram_dout <= pat(bram_addr);
    always @(posedge clk) begin
        if (bram_en2) mid2 <= pat(bram_addr2);
        bram_dout2 <= mid2;
    end

    task automatic do_start(input logic [AW-1:0] b, input logic [7:0] n, input logic [AW-1:0] s);
        @(negedge clk);
        start = 1'b1; base = b; ntiles = n; stride = s;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!busy && !busy2) break;
            @(negedge clk);
        end
        checks++;
        if (busy || busy2) begin
            errors++;
            $display("FAIL wait_idle busy=%b busy2=%b required 0 0", busy, busy2);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; ready = 1'b1; ready2 = 1'b1;
        base = '0; stride = '0; ntiles = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bram_en, bram_addr, out_valid, out_last, tile_done, job_done, busy} !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs en=%b addr=%h v=%b l=%b td=%b jd=%b busy=%b required all 0",
                     bram_en, bram_addr, out_valid, out_last, tile_done, job_done, busy);
        end
        checks++;
        if ({busy2, out_valid2, bram_en2} !== 3'b000) begin
            errors++;
            $display("FAIL reset_dut2 busy=%b v=%b en=%b required 0", busy2, out_valid2, bram_en2);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int nr = 0, nb = 0, first_v = -1, last_hs = -1;
        ready = 1'b1;
        do_start(11'h010, 8'd2, 11'h040);
        for (int cyc = 1; cyc < 200 && nb < 64; cyc++) begin
            #1;
            if (bram_en) begin
                checks++;
                if (bram_addr !== exp_addr(11'h010, 11'h040, nr)) begin
                    errors++;
                    $display("FAIL basic_addr read %0d got %h required %h", nr, bram_addr, exp_addr(11'h010, 11'h040, nr));
                end
                nr++;
            end
            if (out_valid && first_v < 0) first_v = cyc;
            if (out_valid && ready) begin
                checks++;
                if (out_data !== pat(exp_addr(11'h010, 11'h040, nb)) || out_last !== (nb % NF == NF - 1) ||
                    tile_done !== (nb % NF == NF - 1) || job_done !== (nb == 63)) begin
                    errors++;
                    $display("FAIL basic_beat %0d data=%h last=%b td=%b jd=%b", nb, out_data[15:0], out_last, tile_done, job_done);
                end
                nb++;
                last_hs = cyc;
            end
            @(negedge clk);
        end
        #1;
        checks++;
        if (nr != 64 || nb != 64) begin
            errors++;
            $display("FAIL basic_count reads=%0d beats=%0d required 64 64", nr, nb);
        end
        checks++;
        if (first_v != 3 || last_hs != 66) begin
            errors++;
            $display("FAIL basic_timing first_valid=%0d last_beat=%0d required 3 66", first_v, last_hs);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_end busy=%b valid=%b required 0 0", busy, out_valid);
        end
        wait_idle(20);
    endtask

    task automatic test_random_ready();
        int nb = 0, first_v = -1;
        logic stall_prev = 1'b0, plast = 1'b0;
        logic [DW-1:0] pdata = '0;
        ready = 1'b1;
        do_start(11'h100, 8'd1, 11'h040);
        ready2 = 1'($urandom_range(0, 1));
        for (int cyc = 1; cyc < 400 && nb < 32; cyc++) begin
            #1;
            if (stall_prev) begin
                checks++;
                if (out_valid2 !== 1'b1 || out_data2 !== pdata || out_last2 !== plast) begin
                    errors++;
                    $display("FAIL rand_stall beat %0d valid=%b last=%b required 1 %b", nb, out_valid2, out_last2, plast);
                end
            end
            if (out_valid2 && first_v < 0) first_v = cyc;
            if (out_valid2 && ready2) begin
                checks++;
                if (out_data2 !== pat(AW'(11'h100 + nb)) || out_last2 !== (nb == 31) || job_done2 !== (nb == 31)) begin
                    errors++;
                    $display("FAIL rand_beat %0d data=%h last=%b jd=%b", nb, out_data2[15:0], out_last2, job_done2);
                end
                nb++;
            end
            stall_prev = out_valid2 && !ready2;
            pdata = out_data2;
            plast = out_last2;
            @(negedge clk);
            ready2 = 1'($urandom_range(0, 1));
        end
        ready2 = 1'b1;
        checks++;
        if (nb != 32 || first_v != 4) begin
            errors++;
            $display("FAIL rand_summary beats=%0d first_valid=%0d required 32 4", nb, first_v);
        end
        wait_idle(50);
    endtask

    task automatic test_wrap();
        int nr = 0;
        logic [AW-1:0] a16 = '1, a32 = '1, a63 = '1;
        ready = 1'b1;
        do_start(11'h7F0, 8'd2, 11'h020);
        for (int cyc = 1; cyc < 120 && nr < 64; cyc++) begin
            #1;
            if (bram_en) begin
                checks++;
                if (bram_addr !== exp_addr(11'h7F0, 11'h020, nr)) begin
                    errors++;
                    $display("FAIL wrap_addr read %0d got %h required %h", nr, bram_addr, exp_addr(11'h7F0, 11'h020, nr));
                end
                if (nr == 16) a16 = bram_addr;
                if (nr == 32) a32 = bram_addr;
                if (nr == 63) a63 = bram_addr;
                nr++;
            end
            @(negedge clk);
        end
        checks++;
        if (a16 !== 11'h000 || a32 !== 11'h010 || a63 !== 11'h02F) begin
            errors++;
            $display("FAIL wrap_points got %h %h %h required 000 010 02f", a16, a32, a63);
        end
        wait_idle(50);
    endtask

    task automatic test_abort();
        int nb = 0;
        ready = 1'b1;
        do_start(11'h000, 8'd2, 11'h040);
        for (int cyc = 1; cyc < 200 && nb < 42; cyc++) begin
            #1;
            if (out_valid && ready) nb++;
            @(negedge clk);
        end
        abort = 1'b1;
        #1;
        checks++;
        if (job_done !== 1'b0 || tile_done !== 1'b0 || bram_en !== 1'b0) begin
            errors++;
            $display("FAIL abort_cycle jd=%b td=%b en=%b required 0 0 0", job_done, tile_done, bram_en);
        end
        @(negedge clk);
        abort = 1'b0;
        #1;
        checks++;
        if (bram_en !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_next en=%b busy=%b valid=%b required 0 0 0", bram_en, busy, out_valid);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || job_done !== 1'b0 || bram_en !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet cycle %0d valid=%b jd=%b en=%b required 0", i, out_valid, job_done, bram_en);
            end
        end
        wait_idle(20);
        // Restart with abort and start together in IDLE: start must win.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; base = 11'h200; ntiles = 8'd1; stride = 11'h000;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        nb = 0;
        for (int cyc = 1; cyc < 120 && nb < 32; cyc++) begin
            #1;
            if (cyc == 1) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_restart busy=%b required 1", busy);
                end
            end
            if (out_valid && ready) begin
                checks++;
                if (out_data !== pat(AW'(11'h200 + nb)) || job_done !== (nb == 31)) begin
                    errors++;
                    $display("FAIL restart_beat %0d data=%h jd=%b", nb, out_data[15:0], job_done);
                end
                nb++;
            end
            @(negedge clk);
        end
        checks++;
        if (nb != 32) begin
            errors++;
            $display("FAIL restart_count beats=%0d required 32", nb);
        end
        wait_idle(20);
    endtask

    task automatic test_reset_mid();
        ready = 1'b1;
        do_start(11'h000, 8'd2, 11'h040);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bram_en, bram_addr, out_valid, out_last, tile_done, job_done, busy} !== '0 || out_data !== '0) begin
            errors++;
            $display("FAIL rst_mid en=%b addr=%h v=%b l=%b td=%b jd=%b busy=%b required all 0",
                     bram_en, bram_addr, out_valid, out_last, tile_done, job_done, busy);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || out_valid2 !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL rst_inflight cycle %0d valid=%b valid2=%b busy=%b required 0", i, out_valid, out_valid2, busy);
            end
        end
    endtask

    task automatic test_start_ignored();
        int nb = 0;
        ready = 1'b1;
        do_start(11'h300, 8'd1, 11'h000);
        for (int cyc = 1; cyc < 120 && nb < 32; cyc++) begin
            #1;
            if (out_valid && ready) begin
                checks++;
                if (out_data !== pat(AW'(11'h300 + nb)) || job_done !== (nb == 31)) begin
                    errors++;
                    $display("FAIL ignore_beat %0d data=%h jd=%b", nb, out_data[15:0], job_done);
                end
                nb++;
            end
            @(negedge clk);
            start = (cyc == 4);
            if (cyc == 4) begin
                base = 11'h000; ntiles = 8'd3; stride = 11'h100;
            end
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (nb != 32 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignore_end beats=%0d busy=%b valid=%b required 32 0 0", nb, busy, out_valid);
        end
        wait_idle(20);
    endtask

    task automatic test_num_tiles_zero();
        int nb = 0, tiles = 0, jd_at = -1;
        ready = 1'b1;
        do_start(11'h000, 8'd0, 11'h020);
        for (int cyc = 1; cyc < 9000 && jd_at < 0; cyc++) begin
            #1;
            if (out_valid && ready) begin
                checks++;
                if (out_data !== pat(exp_addr(11'h000, 11'h020, nb))) begin
                    errors++;
                    $display("FAIL zero_beat %0d data=%h required %h", nb, out_data[15:0], pat(exp_addr(11'h000, 11'h020, nb)) & 16'hffff);
                end
                if (tile_done) tiles++;
                if (job_done) jd_at = nb;
                nb++;
            end
            @(negedge clk);
        end
        checks++;
        if (nb != 8192 || tiles != 256 || jd_at != 8191) begin
            errors++;
            $display("FAIL zero_tiles beats=%0d tiles=%0d job_done_at=%0d required 8192 256 8191", nb, tiles, jd_at);
        end
        wait_idle(20);
    endtask

`ifdef TILE_FETCH_PERF_CNT_EN
    task automatic test_perf();
        int nb = 0, first_v = -1;
        ready = 1'b1;
        do_start(11'h040, 8'd1, 11'h000);
        for (int cyc = 1; cyc < 120 && nb < 32; cyc++) begin
            #1;
            if (out_valid && first_v < 0) first_v = cyc;
            if (out_valid && ready) nb++;
            @(negedge clk);
            ready = !(first_v > 0 && cyc + 1 > first_v && cyc + 1 <= first_v + 5);
        end
        ready = 1'b1;
        wait_idle(20);
        #1;
        checks++;
        if (stall_cycles !== 32'd5 || nb != 32) begin
            errors++;
            $display("FAIL perf_stall got %0d beats %0d required 5 32", stall_cycles, nb);
        end
        do_start(11'h040, 8'd1, 11'h000);
        #1;
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL perf_clear got %0d required 0", stall_cycles);
        end
        wait_idle(60);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_random_ready();
        test_wrap();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        test_num_tiles_zero();
`ifdef TILE_FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
